// File: rtl/decoder_pipe.sv
// decoder_pipe: binary selector decoder (one-hot or thermometer) behind a
// 2-entry elastic FIFO with valid/ready handshakes on both sides.
//
// Parameters
//   SEL_W    selector width in bits (1..8)
//   NUM_OUT  number of decoded outputs (2..2**SEL_W)
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   upstream request present
//   in_ready   block can accept a request (depends on registered state only)
//   in_sel     binary selector code
//   in_mode    0 = one-hot, 1 = thermometer
//   out_valid  out_y/out_err hold the oldest decoded result
//   out_ready  downstream accepts the current result
//   out_y      decoded vector
//   out_err    selector was >= NUM_OUT (out_y forced to 0)
//   count_o    16-bit wrapping pop counter (only with DECODER_PIPE_COUNT_EN)
//
// Build option: define DECODER_PIPE_COUNT_EN to add the count_o port.
module decoder_pipe #(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned NUM_OUT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] out_y,
`ifdef DECODER_PIPE_COUNT_EN
  output logic [15:0]        count_o,
`endif
  output logic               out_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e               state_q;
  logic [NUM_OUT-1:0]   tail_y_q;
  logic                 tail_err_q;
  logic [NUM_OUT-1:0]   dec_y_d;
  logic                 dec_err_d;
  logic                 push;
  logic                 pop;

  // Handshakes use the registered ready/valid flags only.
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Decode the incoming selector; out-of-range codes produce an error entry.
  always_comb begin
    dec_y_d   = '0;
    dec_err_d = 1'b0;
    if (32'(in_sel) >= NUM_OUT) begin
      dec_err_d = 1'b1;
    end else begin
      for (int unsigned i = 0; i < NUM_OUT; i++) begin
        dec_y_d[i] = in_mode ? (i <= 32'(in_sel)) : (i == 32'(in_sel));
      end
    end
  end

  // FIFO control; out_y/out_err are the head entry, tail_* the second entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_y      <= '0;
      out_err    <= 1'b0;
      tail_y_q   <= '0;
      tail_err_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            out_y     <= dec_y_d;
            out_err   <= dec_err_d;
            state_q   <= ONE;
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            // Head leaves and the new result takes its place.
            out_y   <= dec_y_d;
            out_err <= dec_err_d;
          end else if (push) begin
            tail_y_q   <= dec_y_d;
            tail_err_q <= dec_err_d;
            state_q    <= FULL;
            in_ready   <= 1'b0;
          end else if (pop) begin
            state_q   <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        FULL: begin
          if (pop) begin
            out_y    <= tail_y_q;
            out_err  <= tail_err_q;
            state_q  <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state_q   <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef DECODER_PIPE_COUNT_EN
  // Pop counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_o <= 16'd0;
    end else if (pop) begin
      count_o <= count_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decoder_pipe.sv
// Directed self-checking bench for decoder_pipe. Two instances share the
// stimulus: an 8-output decoder and a 6-output decoder (for range errors).
module tb_decoder_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_sel;
  logic       in_mode;
  logic       out_ready;

  logic       in_ready8, out_valid8, out_err8;
  logic [7:0] out_y8;
  logic       in_ready6, out_valid6, out_err6;
  logic [5:0] out_y6;
`ifdef DECODER_PIPE_COUNT_EN
  logic [15:0] count8, count6;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decoder_pipe #(.SEL_W(3), .NUM_OUT(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready8),
    .in_sel   (in_sel),
    .in_mode  (in_mode),
    .out_valid(out_valid8),
    .out_ready(out_ready),
    .out_y    (out_y8),
`ifdef DECODER_PIPE_COUNT_EN
    .count_o  (count8),
`endif
    .out_err  (out_err8)
  );

  decoder_pipe #(.SEL_W(3), .NUM_OUT(6)) dut6 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready6),
    .in_sel   (in_sel),
    .in_mode  (in_mode),
    .out_valid(out_valid6),
    .out_ready(out_ready),
    .out_y    (out_y6),
`ifdef DECODER_PIPE_COUNT_EN
    .count_o  (count6),
`endif
    .out_err  (out_err6)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic m);
    in_valid = v;
    in_sel   = s;
    in_mode  = m;
  endtask

  logic [7:0] thermo_exp [3];
  logic [2:0] thermo_sel [3];

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 3'd0, 1'b0);

    // Reset state
    #3;
    check("rst_out_valid", 32'(out_valid8), 32'd0);
    check("rst_out_y", 32'(out_y8), 32'd0);
    check("rst_out_err", 32'(out_err8), 32'd0);
    step();
    step();
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready8), 32'd1);

    // One-hot, back-to-back, one cycle latency
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 1'b0);
      step();
      check($sformatf("onehot_valid_%0d", i), 32'(out_valid8), 32'd1);
      check($sformatf("onehot_y_%0d", i), 32'(out_y8), 32'd1 << i);
      check($sformatf("onehot_err_%0d", i), 32'(out_err8), 32'd0);
    end
    drive(1'b0, 3'd0, 1'b0);
    step();
    check("onehot_drained", 32'(out_valid8), 32'd0);

    // Thermometer
    thermo_sel[0] = 3'd3; thermo_exp[0] = 8'h0F;
    thermo_sel[1] = 3'd7; thermo_exp[1] = 8'hFF;
    thermo_sel[2] = 3'd0; thermo_exp[2] = 8'h01;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, thermo_sel[i], 1'b1);
      step();
      check($sformatf("thermo_y_sel%0d", thermo_sel[i]), 32'(out_y8), 32'(thermo_exp[i]));
      check($sformatf("thermo_err_sel%0d", thermo_sel[i]), 32'(out_err8), 32'd0);
    end

    // Out-of-range selectors on the 6-output instance
    drive(1'b1, 3'd6, 1'b0);
    step();
    check("n6_sel6_y", 32'(out_y6), 32'd0);
    check("n6_sel6_err", 32'(out_err6), 32'd1);
    check("n8_sel6_y", 32'(out_y8), 32'h40);
    drive(1'b1, 3'd7, 1'b0);
    step();
    check("n6_sel7_y", 32'(out_y6), 32'd0);
    check("n6_sel7_err", 32'(out_err6), 32'd1);
    check("n6_sel7_valid", 32'(out_valid6), 32'd1);
    drive(1'b1, 3'd5, 1'b1);
    step();
    check("n6_sel5_thermo_y", 32'(out_y6), 32'h3F);
    check("n6_sel5_thermo_err", 32'(out_err6), 32'd0);
    drive(1'b0, 3'd0, 1'b0);
    step();
    check("n6_drained", 32'(out_valid6), 32'd0);

    // Backpressure: fill, ignore third request, then drain in order
    out_ready = 1'b0;
    drive(1'b1, 3'd1, 1'b0);
    step();
    check("bp_first_y", 32'(out_y8), 32'h02);
    check("bp_ready_one", 32'(in_ready8), 32'd1);
    drive(1'b1, 3'd2, 1'b0);
    step();
    check("bp_ready_full", 32'(in_ready8), 32'd0);
    check("bp_hold_y", 32'(out_y8), 32'h02);
    drive(1'b1, 3'd3, 1'b0);
    step();
    check("bp_ignored_ready", 32'(in_ready8), 32'd0);
    check("bp_stable_y", 32'(out_y8), 32'h02);
    drive(1'b0, 3'd4, 1'b1);
    out_ready = 1'b1;
    step();
    check("bp_pop1_y", 32'(out_y8), 32'h04);
    check("bp_pop1_ready", 32'(in_ready8), 32'd1);
    check("bp_pop1_valid", 32'(out_valid8), 32'd1);
    step();
    check("bp_pop2_empty", 32'(out_valid8), 32'd0);

    // Reset while FULL
    out_ready = 1'b0;
    drive(1'b1, 3'd1, 1'b0);
    step();
    drive(1'b1, 3'd2, 1'b0);
    step();
    check("mid_full_ready", 32'(in_ready8), 32'd0);
    drive(1'b0, 3'd0, 1'b0);
    rst = 1'b1;
    #2;
    check("mid_rst_valid", 32'(out_valid8), 32'd0);
    check("mid_rst_y", 32'(out_y8), 32'd0);
    step();
    rst = 1'b0;
    check("mid_rel_ready", 32'(in_ready8), 32'd1);
    check("mid_rel_valid", 32'(out_valid8), 32'd0);
    out_ready = 1'b1;
    drive(1'b1, 3'd5, 1'b0);
    step();
    check("mid_push5_y", 32'(out_y8), 32'h20);
    check("mid_push5_valid", 32'(out_valid8), 32'd1);
    drive(1'b0, 3'd0, 1'b0);
    step();
    check("mid_drained", 32'(out_valid8), 32'd0);

`ifdef DECODER_PIPE_COUNT_EN
    // 65537 pops wrap the counter to 1
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("cnt_reset", 32'(count8), 32'd0);
    drive(1'b1, 3'd0, 1'b0);
    for (int i = 0; i < 65537; i++) step();
    drive(1'b0, 3'd0, 1'b0);
    step();
    check("cnt_wrap", 32'(count8), 32'd1);
    check("cnt_wrap_n6", 32'(count6), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
